// File: rtl/modulo_ctrl_matriz.sv
// Column-scan controller for a 5-column LED matrix with a 4-state display selector.
// Optional auto-cycling of display states is enabled by defining MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN.
module modulo_ctrl_matriz #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned FRAMES_PER_STA = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_next,
    input  logic       clr,
    output logic [1:0] sta,
    output logic [4:0] col,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned PRESC_W = 16;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned FCNT_W  = 8;
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(4);

    if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_scan_div
        $error("SCAN_DIV out of range 2..65535");
    end
    if (FRAMES_PER_STA < 1 || FRAMES_PER_STA > 255) begin : g_bad_frames
        $error("FRAMES_PER_STA out of range 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHOW_A = 2'b01,
        SHOW_B = 2'b10,
        SHOW_C = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic                 start_q, next_q;
    logic                 pending_q, pending_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4:0]           col_d;
    logic                 frame_done_d;
    logic                 start_rise, next_rise;
    logic                 tick, manual, advance;
`ifdef MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
`endif

    assign start_rise = btn_start & ~start_q;
    assign next_rise  = btn_next & ~next_q;
    assign sta        = state_q;
    assign busy       = (state_q != IDLE);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            next_q     <= 1'b0;
            pending_q  <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            col        <= '0;
            frame_done <= 1'b0;
`ifdef MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN
            fcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= btn_start;
            next_q     <= btn_next;
            pending_q  <= pending_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            col        <= col_d;
            frame_done <= frame_done_d;
`ifdef MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN
            fcnt_q     <= fcnt_d;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        presc_d      = presc_q;
        idx_d        = idx_q;
        col_d        = col;
        frame_done_d = 1'b0;
        tick         = 1'b0;
        manual       = 1'b0;
        advance      = 1'b0;
`ifdef MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN
        fcnt_d       = fcnt_q;
`endif

        if (clr) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            presc_d   = '0;
            idx_d     = '0;
            col_d     = '0;
`ifdef MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN
            fcnt_d    = '0;
`endif
        end else if (state_q == IDLE) begin
            pending_d = 1'b0;
            presc_d   = '0;
            idx_d     = '0;
            col_d     = '0;
`ifdef MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN
            fcnt_d    = '0;
`endif
            if (start_rise) begin
                state_d = SHOW_A;
                col_d   = 5'b00001;
            end
        end else begin
            tick    = (presc_q == PRESC_TC);
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            if (tick) begin
                idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                frame_done_d = (idx_q == IDX_LAST);
            end
            col_d = 5'b00001 << idx_d;

            // Advances are only taken while the frame_done pulse is visible
            if (frame_done) begin
                manual  = pending_q | next_rise;
                advance = manual;
`ifdef MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN
                if (manual || (fcnt_q + FCNT_W'(1)) == FCNT_W'(FRAMES_PER_STA)) begin
                    advance = 1'b1;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                end
`endif
                pending_d = 1'b0;
            end else if (next_rise) begin
                pending_d = 1'b1;
            end

            if (advance) begin
                case (state_q)
                    SHOW_A:  state_d = SHOW_B;
                    SHOW_B:  state_d = SHOW_C;
                    default: state_d = SHOW_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modulo_ctrl_matriz.sv
// Scoreboard bench for modulo_ctrl_matriz with SCAN_DIV=4, FRAMES_PER_STA=2.
// Expected frame_done events (cycle, sta during pulse, sta after) are queued by stimulus and popped by a monitor.
module tb_modulo_ctrl_matriz;

    localparam int unsigned SCAN_DIV       = 4;
    localparam int unsigned FRAMES_PER_STA = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_next  = 1'b0;
    logic       clr       = 1'b0;
    logic [1:0] sta;
    logic [4:0] col;
    logic       frame_done;
    logic       busy;

    modulo_ctrl_matriz #(
        .SCAN_DIV       (SCAN_DIV),
        .FRAMES_PER_STA (FRAMES_PER_STA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_start  (btn_start),
        .btn_next   (btn_next),
        .clr        (clr),
        .sta        (sta),
        .col        (col),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] sta;
        logic [1:0] sta_after;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] s, input logic [1:0] sa);
        exp_t e;
        e.cyc       = c;
        e.sta       = s;
        e.sta_after = sa;
        q.push_back(e);
    endtask

    // Monitor: every frame_done pulse must match the head of the queue
    logic       after_pend = 1'b0;
    logic [1:0] after_sta  = 2'b00;
    always @(negedge clk) begin
        exp_t e;
        if (after_pend) begin
            check("sta_after_frame_done", 32'(sta), 32'(after_sta));
            after_pend = 1'b0;
        end
        if (rst_n && frame_done) begin
            if (q.size() == 0) begin
                check("frame_done_unexpected", 32'(frame_done), 32'd0);
            end else begin
                e = q.pop_front();
                check("frame_done_cycle", 32'(cyc), 32'(e.cyc));
                check("frame_done_sta", 32'(sta), 32'(e.sta));
                check("frame_done_busy", 32'(busy), 32'd1);
                after_sta  = e.sta_after;
                after_pend = 1'b1;
            end
        end
    end

    // Advance to just after the posedge that starts cycle t
    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance to the negedge inside cycle t
    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_start(output int c);
        @(posedge clk);
        #1;
        btn_start = 1'b1;
        c = cyc;
        @(posedge clk);
        #1;
        btn_start = 1'b0;
    endtask

    task automatic next_at(input int t);
        go(t);
        btn_next = 1'b1;
        @(posedge clk);
        #1;
        btn_next = 1'b0;
    endtask

    task automatic check_outputs(input string name, input logic [1:0] s, input logic [4:0] c,
                                 input logic fd, input logic b);
        check({name, "_sta"}, 32'(sta), 32'(s));
        check({name, "_col"}, 32'(col), 32'(c));
        check({name, "_frame_done"}, 32'(frame_done), 32'(fd));
        check({name, "_busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        int c, e, e2, e3;
        #1;
        check_outputs("reset", 2'b00, 5'b00000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("idle_after_reset", 2'b00, 5'b00000, 1'b0, 1'b0);

`ifdef MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN
        pulse_start(c);
        e = c + 1;
        check_outputs("auto_entry", 2'b01, 5'b00001, 1'b0, 1'b1);
        push(e + 20,  2'b01, 2'b01);
        push(e + 40,  2'b01, 2'b10);
        push(e + 60,  2'b10, 2'b10);
        push(e + 80,  2'b10, 2'b11);
        push(e + 100, 2'b11, 2'b11);
        push(e + 120, 2'b11, 2'b01);
        push(e + 140, 2'b01, 2'b01);
        push(e + 160, 2'b01, 2'b10);
        push(e + 180, 2'b10, 2'b10);
        next_at(e + 150);
        at(e + 185);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_outputs("auto_clr", 2'b00, 5'b00000, 1'b0, 1'b0);
        at(cyc + 10);
`else
        // Entry and column stepping
        pulse_start(c);
        e = c + 1;
        check_outputs("entry", 2'b01, 5'b00001, 1'b0, 1'b1);
        push(e + 20,  2'b01, 2'b01);
        push(e + 40,  2'b01, 2'b10);
        push(e + 60,  2'b10, 2'b10);
        push(e + 80,  2'b10, 2'b11);
        push(e + 100, 2'b11, 2'b01);
        at(e + 4);  check("col_step1", 32'(col), 32'h02);
        at(e + 8);  check("col_step2", 32'(col), 32'h04);
        at(e + 12); check("col_step3", 32'(col), 32'h08);
        at(e + 16); check("col_step4", 32'(col), 32'h10);
        at(e + 20); check("col_wrap", 32'(col), 32'h01);

        // Three presses in one frame give one advance
        next_at(e + 25);
        next_at(e + 27);
        next_at(e + 29);
        at(e + 39); check("no_early_advance", 32'(sta), 32'd1);
        at(e + 45); check("single_advance", 32'(sta), 32'd2);

        // To SHOW_C, then a press coinciding with frame_done wraps to SHOW_A
        next_at(e + 65);
        at(e + 85); check("show_c", 32'(sta), 32'd3);
        check("show_c_busy", 32'(busy), 32'd1);
        next_at(e + 100);
        at(e + 101); check("wrap_busy", 32'(busy), 32'd1);

        // clr overrides btn_next mid-frame
        go(e + 110);
        clr = 1'b1;
        btn_next = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        btn_next = 1'b0;
        check_outputs("clr", 2'b00, 5'b00000, 1'b0, 1'b0);
        at(e + 150);
        check("queue_drained_after_clr", 32'(q.size()), 32'd0);
        check("idle_holds_after_clr", 32'(sta), 32'd0);

        // Asynchronous reset mid-frame in SHOW_B
        pulse_start(c);
        e2 = c + 1;
        push(e2 + 20, 2'b01, 2'b10);
        next_at(e2 + 5);
        go(e2 + 30);
        check("pre_reset_sta", 32'(sta), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 2'b00, 5'b00000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        next_at(cyc + 3);
        at(cyc + 20);
        check_outputs("idle_ignores_next", 2'b00, 5'b00000, 1'b0, 1'b0);
        pulse_start(c);
        e3 = c + 1;
        check_outputs("restart", 2'b01, 5'b00001, 1'b0, 1'b1);
        push(e3 + 20, 2'b01, 2'b01);
        at(e3 + 25);

        // btn_start held through reset release counts as a rising edge
        rst_n = 1'b0;
        btn_start = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("start_held_through_reset", 32'(sta), 32'd1);
        btn_start = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        at(cyc + 5);
`endif
        check("queue_drained_final", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/modulo_ctrl_matriz.md
MODULO_CTRL_MATRIZ -- requirements
Module: modulo_ctrl_matriz

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per column step; legal range 2..65535.
REQ-002 Parameter FRAMES_PER_STA, default 60: frames per display state in auto-cycle mode; legal range 1..255.
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btn_start  input  1  synchronous level; its rising edge starts display from idle.
REQ-006 btn_next  input  1  synchronous level; its rising edge requests the next display state.
REQ-007 clr  input  1  synchronous level; returns the block to idle.
REQ-008 sta  output  2  display state code driven to the matrix input selector.
REQ-009 col  output  5  one-hot active-high column enable.
REQ-010 frame_done  output  1  one-cycle pulse at the end of each full 5-column frame.
REQ-011 busy  output  1  high whenever sta != 2'b00.

Function
REQ-012 The FSM SHALL have four states encoded directly on sta: IDLE=00, SHOW_A=01, SHOW_B=10, SHOW_C=11.
REQ-013 IDLE SHALL go to SHOW_A on the cycle after a btn_start rising edge is detected (registered previous value, 1-cycle latency).
REQ-014 In any SHOW state, btn_start SHALL be ignored.
REQ-015 A btn_next rising edge in a SHOW state SHALL set a pending flag; further edges before it is consumed SHALL NOT queue more than one advance.
REQ-016 The pending advance SHALL be applied only in the cycle frame_done is high: SHOW_A->SHOW_B->SHOW_C->SHOW_A (wrap), clearing pending.
REQ-017 A btn_next edge coinciding with frame_done SHALL be applied at that frame_done.
REQ-018 btn_next edges in IDLE SHALL be ignored and SHALL NOT set pending.
REQ-019 clr high SHALL, next cycle, force IDLE, col=0, and clear pending, prescaler, column index and frame counter; clr SHALL override btn_start/btn_next in the same cycle.
REQ-020 The 16-bit prescaler SHALL count 0..SCAN_DIV-1 only in SHOW states; a tick occurs at terminal count.
REQ-021 Each tick SHALL advance the column index 0..4, wrapping 4->0; col = 1<<index in SHOW states, 5'b00000 in IDLE.
REQ-022 frame_done SHALL pulse for exactly one cycle on the tick that wraps index 4->0; the first frame therefore ends 5*SCAN_DIV cycles after entering SHOW_A.
REQ-023 On entering SHOW_A from IDLE, the prescaler and index SHALL start at 0 (col=00001).
REQ-024 busy SHALL be combinationally derived from sta.

Reset
REQ-025 rst_n low SHALL immediately set sta=00, col=00000, frame_done=0, busy=0, and clear pending, the prescaler, the index, the frame counter and the edge-detect registers.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; after release the block SHALL wait in IDLE for btn_start.
REQ-027 Edge-detect registers SHALL reset to 0, so an input held high through reset release SHALL register as a rising edge on the first clock.

Configuration
REQ-028 Macro MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN: when defined, an 8-bit frame counter SHALL count frame_done pulses in SHOW states and SHALL force an advance at frame FRAMES_PER_STA, then reset to 0.
REQ-029 With the macro defined, a manual advance via btn_next SHALL also reset the frame counter; a manual and an auto advance on the same frame_done SHALL produce a single advance.
REQ-030 When the macro is undefined, the frame counter SHALL be absent and states SHALL change only via btn_start, btn_next, clr and rst_n.

Verification (SCAN_DIV=4, FRAMES_PER_STA=2)
REQ-031 Reset release, btn_start pulse -> sta=01 next cycle; col steps 00001,00010,...,10000 every 4 clocks; frame_done high at cycle 20 after entry.
REQ-032 In SHOW_A, three btn_next pulses in one frame -> a single advance to sta=10 on the next frame_done only.
REQ-033 From SHOW_C, btn_next then frame_done -> sta=01 (wrap); busy stays 1 throughout.
REQ-034 clr and btn_next asserted in the same cycle mid-frame -> sta=00, col=00000 next cycle; no later frame_done pulse.
REQ-035 rst_n pulsed low mid-frame in SHOW_B -> outputs zero immediately, asynchronously; after release, btn_next has no effect and btn_start restarts at SHOW_A with col=00001.
REQ-036 With MODULO_CTRL_MATRIZ_AUTO_CYCLE_EN defined and no buttons pressed after start -> sta 01->10 after the 2nd frame_done, 10->11 after the 4th, 11->01 after the 6th.
